// File: rtl/bram_axi_master_if.sv
// ============================================================================
// Module   : AXI_BUS
// Brief    : AXI4 bus bundle with initiator (Master) and target (Slave) views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

`default_nettype wire

// File: rtl/bram_axi_master.sv
// ============================================================================
// Module   : bram_axi_master
// Brief    : BRAM-style request port to single-beat AXI4 initiator.
//            Optional macro BRAM_AXI_MASTER_TRACE_EN enables last_addr_o trace.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_axi_master #(
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst,
  input  logic                        req_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output logic [AXI_ADDR_WIDTH-1:0]   last_addr_o,
  AXI_BUS.Master                      master
);
  localparam int unsigned            C_STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ID_WIDTH-1:0] C_ID    = AXI_ID_WIDTH'(AXI_ID);
  localparam logic [2:0]             C_SIZE   = 3'($clog2(C_STRB_W));
  localparam logic [1:0]             C_INCR   = 2'b01;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;

  logic [2:0]                r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [C_STRB_W-1:0]       r_we;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic                      r_aw_valid;
  logic                      r_w_valid;
  logic                      r_ar_valid;
  logic                      r_rvalid;
  logic                      r_err;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;

  logic w_gnt;
  logic w_aw_done;
  logic w_w_done;
  logic w_unused_bits;

  // rst is folded in so the grant disappears the instant reset is asserted.
  assign w_gnt     = req_i & (r_state == ST_IDLE) & ~rst;
  assign w_aw_done = ~r_aw_valid | master.aw_ready;
  assign w_w_done  = ~r_w_valid | master.w_ready;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_we       <= '0;
      r_wdata    <= '0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_ar_valid <= 1'b0;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt) begin
            r_addr  <= addr_i;
            r_we    <= we_i;
            r_wdata <= wdata_i;
            if (|we_i) begin
              r_state    <= ST_WR;
              r_aw_valid <= 1'b1;
              r_w_valid  <= 1'b1;
            end else begin
              r_state    <= ST_RD_ADDR;
              r_ar_valid <= 1'b1;
            end
          end
        end
        ST_WR: begin
          // AW and W retire independently; move on once neither is pending.
          if (r_aw_valid && master.aw_ready) r_aw_valid <= 1'b0;
          if (r_w_valid && master.w_ready)   r_w_valid  <= 1'b0;
          if (w_aw_done && w_w_done)         r_state    <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (master.b_valid) begin
            r_state  <= ST_IDLE;
            r_rvalid <= 1'b1;
            r_err    <= master.b_resp[1];
          end
        end
        ST_RD_ADDR: begin
          if (master.ar_ready) begin
            r_ar_valid <= 1'b0;
            r_state    <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (master.r_valid && master.r_last) begin
            r_state  <= ST_IDLE;
            r_rvalid <= 1'b1;
            r_err    <= master.r_resp[1];
            r_rdata  <= master.r_data;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRAM_AXI_MASTER_TRACE_EN
  logic [AXI_ADDR_WIDTH-1:0] r_last_addr;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_last_addr <= '0;
    end else if (w_gnt) begin
      r_last_addr <= addr_i;
    end
  end

  assign last_addr_o = r_last_addr;
`else
  assign last_addr_o = '0;
`endif

  assign gnt_o    = w_gnt;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

  assign master.aw_id     = C_ID;
  assign master.aw_addr   = r_addr;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = C_SIZE;
  assign master.aw_burst  = C_INCR;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = 4'd0;
  assign master.aw_prot   = 3'd0;
  assign master.aw_qos    = 4'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_user   = '0;
  assign master.aw_valid  = r_aw_valid;

  assign master.w_data  = r_wdata;
  assign master.w_strb  = r_we;
  assign master.w_last  = 1'b1;
  assign master.w_user  = '0;
  assign master.w_valid = r_w_valid;

  assign master.b_ready = (r_state == ST_WR_RESP);

  assign master.ar_id     = C_ID;
  assign master.ar_addr   = r_addr;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = C_SIZE;
  assign master.ar_burst  = C_INCR;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = 4'd0;
  assign master.ar_prot   = 3'd0;
  assign master.ar_qos    = 4'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_user   = '0;
  assign master.ar_valid  = r_ar_valid;

  assign master.r_ready = (r_state == ST_RD_DATA);

  // Response IDs, user bits and resp[0] carry nothing this initiator acts on.
  assign w_unused_bits = ^{master.b_id, master.b_user, master.b_resp[0],
                           master.r_id, master.r_user, master.r_resp[0]};

endmodule

`default_nettype wire

// File: tb/tb_bram_axi_master.sv
// ============================================================================
// Module   : tb_bram_axi_master
// Brief    : Self-checking bench for bram_axi_master with a scripted AXI slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_axi_master;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst   = 1'b1;
  logic          req_i = 1'b0;
  logic [SW-1:0] we_i  = '0;
  logic [AW-1:0] addr_i  = '0;
  logic [DW-1:0] wdata_i = '0;
  logic          gnt_o;
  logic          rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          err_o;
  logic [AW-1:0] last_addr_o;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) bus ();

  bram_axi_master #(
    .AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(1), .AXI_ID(0)
  ) dut (
    .clk_i(clk_i), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .last_addr_o(last_addr_o), .master(bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          is_rd;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [DW-1:0] last_rd = '0;
  int            n_vec = 0;
  int            n_err = 0;

  int            s_aw_delay = 0, s_w_delay = 0, s_b_delay = 0, s_ar_delay = 0, s_r_delay = 0;
  logic [1:0]    s_bresp = 2'b00, s_rresp = 2'b00;
  logic [DW-1:0] s_rdata = '0;

  // Scripted slave: reacts on negedge to DUT outputs that changed on posedge.
  initial begin
    int  aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit  aw_hs, w_hs, ar_hs, b_fire, r_fire;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; b_fire = 0; r_fire = 0;
    bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
    bus.b_valid = 0; bus.b_resp = 0; bus.b_id = 0; bus.b_user = 0;
    bus.r_valid = 0; bus.r_resp = 0; bus.r_id = 0; bus.r_user = 0; bus.r_data = 0; bus.r_last = 0;
    forever begin
      @(negedge clk_i);
      if (rst) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_fire = 0; r_fire = 0;
        bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
        bus.b_valid = 0; bus.r_valid = 0; bus.r_last = 0;
      end else begin
        if (b_fire) begin
          bus.b_valid = 0; b_fire = 0;
        end else if (aw_hs && w_hs && !bus.b_valid) begin
          if (b_wait >= s_b_delay) begin bus.b_valid = 1; bus.b_resp = s_bresp; end
          else b_wait++;
        end
        if (bus.b_valid && bus.b_ready) begin b_fire = 1; aw_hs = 0; w_hs = 0; b_wait = 0; end

        if (r_fire) begin
          bus.r_valid = 0; bus.r_last = 0; r_fire = 0;
        end else if (ar_hs && !bus.r_valid) begin
          if (r_wait >= s_r_delay) begin
            bus.r_valid = 1; bus.r_last = 1; bus.r_data = s_rdata; bus.r_resp = s_rresp;
          end else r_wait++;
        end
        if (bus.r_valid && bus.r_ready) begin r_fire = 1; ar_hs = 0; r_wait = 0; end

        if (bus.aw_valid && !aw_hs) begin
          if (aw_wait >= s_aw_delay) begin bus.aw_ready = 1; aw_hs = 1; end
          else begin bus.aw_ready = 0; aw_wait++; end
        end else begin bus.aw_ready = 0; aw_wait = 0; end

        if (bus.w_valid && !w_hs) begin
          if (w_wait >= s_w_delay) begin bus.w_ready = 1; w_hs = 1; end
          else begin bus.w_ready = 0; w_wait++; end
        end else begin bus.w_ready = 0; w_wait = 0; end

        if (bus.ar_valid && !ar_hs) begin
          if (ar_wait >= s_ar_delay) begin bus.ar_ready = 1; ar_hs = 1; end
          else begin bus.ar_ready = 0; ar_wait++; end
        end else begin bus.ar_ready = 0; ar_wait = 0; end
      end
    end
  end

  // Waits for rvalid_o, sampling 1 time unit after each negedge; n = cycles waited.
  task automatic wait_rvalid(input int max, output int n, output bit ok);
    n = 0; ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_i); #1;
      n++;
      if (rvalid_o) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    int n; bit ok;
    req_i = 1'b1; we_i = '0; addr_i = 32'h0000_0100;
    s_rdata = 64'hA5A5_0000_0000_5A5A;
    #2;
    n_vec++; if (gnt_o !== 1'b0) begin n_err++; $display("FAIL rst_gnt: gnt_o=%0b required 0", gnt_o); end
    n_vec++; if ({rvalid_o, err_o} !== 2'b00) begin n_err++; $display("FAIL rst_flags: rvalid/err=%b required 00", {rvalid_o, err_o}); end
    n_vec++; if (rdata_o !== '0 || last_addr_o !== '0) begin n_err++; $display("FAIL rst_data: rdata=%h last_addr=%h required 0", rdata_o, last_addr_o); end
    n_vec++; if ({bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready} !== 5'b0) begin
      n_err++; $display("FAIL rst_axi: aw/w/ar/b/r=%b required 00000", {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}); end
    @(negedge clk_i); #2 rst = 1'b0;
    #1;
    n_vec++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL rst_first_gnt: gnt_o=%0b required 1", gnt_o); end
    sb.push_back('{is_rd: 1'b1, data: s_rdata, err: 1'b0});
    last_rd = s_rdata;
    @(negedge clk_i); req_i = 1'b0; #1;
    n_vec++; if (bus.ar_valid !== 1'b1) begin n_err++; $display("FAIL rst_first_ar: ar_valid=%0b required 1", bus.ar_valid); end
    wait_rvalid(50, n, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rst_first_done: rvalid_o not seen, required within 50 cycles"); end
    else begin
      e = sb.pop_front();
      if (rdata_o !== e.data || err_o !== e.err) begin n_err++; $display("FAIL rst_first_done: rdata=%h err=%0b required %h %0b", rdata_o, err_o, e.data, e.err); end
    end
  endtask

  task automatic test_write();
    int n; bit ok;
    s_aw_delay = 0; s_w_delay = 0; s_b_delay = 0; s_bresp = 2'b00;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 8'hFF; addr_i = 32'h4000_0010; wdata_i = 64'hDEAD_BEEF_0123_4567;
    #1;
    n_vec++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL wr_gnt: gnt_o=%0b required 1", gnt_o); end
    sb.push_back('{is_rd: 1'b0, data: last_rd, err: 1'b0});
    @(negedge clk_i); req_i = 1'b0; we_i = '0; #1;
    n_vec++; if (bus.aw_valid !== 1'b1 || bus.w_valid !== 1'b1) begin n_err++; $display("FAIL wr_valid: aw/w=%b required 11", {bus.aw_valid, bus.w_valid}); end
    n_vec++; if (bus.aw_addr !== 32'h4000_0010) begin n_err++; $display("FAIL wr_aw_addr: %h required 40000010", bus.aw_addr); end
    n_vec++; if (bus.w_strb !== 8'hFF || bus.w_last !== 1'b1 || bus.w_data !== 64'hDEAD_BEEF_0123_4567) begin
      n_err++; $display("FAIL wr_w_fields: strb=%h last=%0b data=%h required ff 1 deadbeef01234567", bus.w_strb, bus.w_last, bus.w_data); end
    n_vec++; if (bus.aw_len !== 8'd0 || bus.aw_size !== 3'd3 || bus.aw_burst !== 2'b01 || bus.aw_id !== 4'd0) begin
      n_err++; $display("FAIL wr_aw_const: len=%0d size=%0d burst=%0d id=%0d required 0 3 1 0", bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_id); end
    wait_rvalid(50, n, ok);
    n_vec++;
    if (!ok || n != 2) begin n_err++; $display("FAIL wr_latency: rvalid_o at cycle %0d (seen=%0b) required cycle 3", n + 1, ok); end
    if (ok) begin
      e = sb.pop_front();
      n_vec++; if (err_o !== e.err || rdata_o !== e.data) begin n_err++; $display("FAIL wr_resp: err=%0b rdata=%h required %0b %h", err_o, rdata_o, e.err, e.data); end
    end
    @(negedge clk_i); #1;
    n_vec++; if (rvalid_o !== 1'b0) begin n_err++; $display("FAIL wr_pulse: rvalid_o=%0b required 0", rvalid_o); end
  endtask

  task automatic test_read();
    int n; bit ok; int extra;
    s_ar_delay = 0; s_r_delay = 5; s_rresp = 2'b00; s_rdata = 64'h1122_3344_5566_7788;
    @(negedge clk_i);
    req_i = 1'b1; we_i = '0; addr_i = 32'h4200_0008;
    #1;
    n_vec++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL rd_gnt: gnt_o=%0b required 1", gnt_o); end
    sb.push_back('{is_rd: 1'b1, data: 64'h1122_3344_5566_7788, err: 1'b0});
    last_rd = 64'h1122_3344_5566_7788;
    @(negedge clk_i); req_i = 1'b0; #1;
    n_vec++; if (bus.ar_valid !== 1'b1 || bus.ar_addr !== 32'h4200_0008) begin n_err++; $display("FAIL rd_ar: valid=%0b addr=%h required 1 42000008", bus.ar_valid, bus.ar_addr); end
    n_vec++; if (bus.ar_len !== 8'd0 || bus.ar_size !== 3'd3) begin n_err++; $display("FAIL rd_ar_const: len=%0d size=%0d required 0 3", bus.ar_len, bus.ar_size); end
`ifdef BRAM_AXI_MASTER_TRACE_EN
    n_vec++; if (last_addr_o !== 32'h4200_0008) begin n_err++; $display("FAIL rd_trace: last_addr_o=%h required 42000008", last_addr_o); end
`else
    n_vec++; if (last_addr_o !== 32'h0) begin n_err++; $display("FAIL rd_trace: last_addr_o=%h required 0", last_addr_o); end
`endif
    wait_rvalid(50, n, ok);
    n_vec++;
    if (!ok || n != 7) begin n_err++; $display("FAIL rd_latency: rvalid_o at cycle %0d (seen=%0b) required cycle 8", n + 1, ok); end
    if (ok) begin
      e = sb.pop_front();
      n_vec++; if (rdata_o !== e.data || err_o !== e.err) begin n_err++; $display("FAIL rd_data: rdata=%h err=%0b required %h %0b", rdata_o, err_o, e.data, e.err); end
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i); #1;
      if (rvalid_o) extra++;
    end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL rd_single_pulse: %0d extra rvalid_o cycles required 0", extra); end
    n_vec++; if (rdata_o !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL rd_hold: rdata=%h required 1122334455667788", rdata_o); end
  endtask

  task automatic test_skewed_write();
    int n; bit ok; int bad;
    s_aw_delay = 4; s_w_delay = 0; s_b_delay = 0; s_bresp = 2'b00;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 8'h3C; addr_i = 32'h4000_0040; wdata_i = 64'h0F0F_0F0F_F0F0_F0F0;
    #1;
    sb.push_back('{is_rd: 1'b0, data: last_rd, err: 1'b0});
    @(negedge clk_i); req_i = 1'b0; #1;
    n_vec++; if ({bus.aw_valid, bus.w_valid} !== 2'b11) begin n_err++; $display("FAIL skew_start: aw/w=%b required 11", {bus.aw_valid, bus.w_valid}); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); #1;
      if (bus.w_valid !== 1'b0 || bus.aw_valid !== 1'b1 || bus.b_ready !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL skew_hold: %0d cycles wrong aw/w/b_ready, required aw=1 w=0 b_ready=0", bad); end
    @(negedge clk_i); #1;
    n_vec++; if ({bus.aw_valid, bus.b_ready} !== 2'b01) begin n_err++; $display("FAIL skew_resp: aw_valid/b_ready=%b required 01", {bus.aw_valid, bus.b_ready}); end
    wait_rvalid(50, n, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL skew_done: rvalid_o not seen, required within 50 cycles"); end
    else begin
      e = sb.pop_front();
      if (err_o !== e.err || rdata_o !== e.data) begin n_err++; $display("FAIL skew_done: err=%0b rdata=%h required %0b %h", err_o, rdata_o, e.err, e.data); end
    end
    // Opposite order: address first, data three cycles later.
    s_aw_delay = 0; s_w_delay = 3;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 8'h01; addr_i = 32'h4000_0048; wdata_i = 64'h55;
    #1;
    sb.push_back('{is_rd: 1'b0, data: last_rd, err: 1'b0});
    @(negedge clk_i); req_i = 1'b0; #1;
    @(negedge clk_i); #1;
    n_vec++; if ({bus.aw_valid, bus.w_valid, bus.b_ready} !== 3'b010) begin n_err++; $display("FAIL skew_rev: aw/w/b_ready=%b required 010", {bus.aw_valid, bus.w_valid, bus.b_ready}); end
    wait_rvalid(50, n, ok);
    n_vec++;
    if (!ok || n != 4) begin n_err++; $display("FAIL skew_rev_done: rvalid_o after %0d cycles (seen=%0b) required 4", n, ok); end
    if (ok) e = sb.pop_front();
  endtask

  task automatic test_back_to_back();
    int n; bit ok; int bad;
    s_ar_delay = 0; s_r_delay = 1; s_rresp = 2'b10; s_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    s_aw_delay = 0; s_w_delay = 0; s_bresp = 2'b00;
    @(negedge clk_i);
    req_i = 1'b1; we_i = '0; addr_i = 32'h4200_0010;
    #1;
    n_vec++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL b2b_gnt0: gnt_o=%0b required 1", gnt_o); end
    sb.push_back('{is_rd: 1'b1, data: 64'hBAD0_BAD0_BAD0_BAD0, err: 1'b1});
    last_rd = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk_i);
    we_i = 8'h0F; addr_i = 32'h4000_0020; wdata_i = 64'h0000_0000_CAFE_F00D;
    #1;
    bad = 0; ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (rvalid_o) begin ok = 1; break; end
      if (gnt_o !== 1'b0) bad++;
      @(negedge clk_i); #1;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL b2b_busy_gnt: gnt_o high in %0d busy cycles required 0", bad); end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL b2b_err: rvalid_o not seen, required within 50 cycles"); end
    else begin
      e = sb.pop_front();
      if (err_o !== e.err || rdata_o !== e.data) begin n_err++; $display("FAIL b2b_err: err=%0b rdata=%h required %0b %h", err_o, rdata_o, e.err, e.data); end
    end
    n_vec++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL b2b_regrant: gnt_o=%0b in rvalid_o cycle required 1", gnt_o); end
    sb.push_back('{is_rd: 1'b0, data: last_rd, err: 1'b0});
    @(negedge clk_i); req_i = 1'b0; we_i = '0; #1;
    n_vec++; if (bus.aw_valid !== 1'b1 || bus.w_strb !== 8'h0F || bus.aw_addr !== 32'h4000_0020) begin
      n_err++; $display("FAIL b2b_wr: aw_valid=%0b strb=%h addr=%h required 1 0f 40000020", bus.aw_valid, bus.w_strb, bus.aw_addr); end
    wait_rvalid(50, n, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL b2b_wr_done: rvalid_o not seen, required within 50 cycles"); end
    else begin
      e = sb.pop_front();
      if (err_o !== e.err || rdata_o !== e.data) begin n_err++; $display("FAIL b2b_wr_done: err=%0b rdata=%h required %0b %h", err_o, rdata_o, e.err, e.data); end
    end
  endtask

  task automatic test_reset_mid_read();
    int n; bit ok;
    s_ar_delay = 10; s_r_delay = 0; s_rresp = 2'b00; s_rdata = 64'h7777;
    @(negedge clk_i);
    req_i = 1'b1; we_i = '0; addr_i = 32'h4200_0030;
    #1;
    sb.push_back('{is_rd: 1'b1, data: 64'h7777, err: 1'b0});
    @(negedge clk_i); req_i = 1'b0; #1;
    n_vec++; if (bus.ar_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre: ar_valid=%0b required 1", bus.ar_valid); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (bus.ar_valid !== 1'b0) begin n_err++; $display("FAIL mid_ar: ar_valid=%0b required 0", bus.ar_valid); end
    n_vec++; if (last_addr_o !== '0 || rdata_o !== '0 || err_o !== 1'b0) begin
      n_err++; $display("FAIL mid_regs: last_addr=%h rdata=%h err=%0b required 0 0 0", last_addr_o, rdata_o, err_o); end
    sb.delete();
    last_rd = '0;
    repeat (2) @(negedge clk_i);
    #2 rst = 1'b0;
    wait_rvalid(20, n, ok);
    n_vec++; if (ok) begin n_err++; $display("FAIL mid_no_rvalid: rvalid_o=1 after reset release required 0"); end
    n_vec++; if (bus.ar_valid !== 1'b0 || bus.r_ready !== 1'b0) begin n_err++; $display("FAIL mid_idle: ar_valid/r_ready=%b required 00", {bus.ar_valid, bus.r_ready}); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_skewed_write();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire

// File: doc/bram_axi_master.md
BRAM_AXI_MASTER -- requirements
Module: bram_axi_master

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- AXI_ID_WIDTH, 4, AXI ID width.
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 64, AXI data width.
- AXI_USER_WIDTH, 1, AXI user width.
- AXI_ID, 0, constant ID driven on AW/AR.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- req_i, in, 1, request valid.
- we_i, in, AXI_DATA_WIDTH/8, byte write enables (0 = read).
- addr_i, in, AXI_ADDR_WIDTH, byte address.
- wdata_i, in, AXI_DATA_WIDTH, write data.
- gnt_o, out, 1, request accepted.
- rvalid_o, out, 1, completion pulse (read or write).
- rdata_o, out, AXI_DATA_WIDTH, read data.
- err_o, out, 1, response error, valid with rvalid_o.
- last_addr_o, out, AXI_ADDR_WIDTH, trace address.
- master, AXI_BUS.Master, -, AXI4 initiator port.

Function
REQ-004 The block SHALL convert BRAM-style requests into single-beat AXI4 transactions; it is the initiator counterpart of axi_ram_wrap.
REQ-005 States SHALL be IDLE, WR, WR_RESP, RD_ADDR and RD_DATA.
REQ-006 gnt_o SHALL equal req_i AND (state==IDLE), combinationally; only one transaction is outstanding.
REQ-007 On grant, addr_i, we_i and wdata_i SHALL be registered. Next state SHALL be WR when we_i!=0, else RD_ADDR.
REQ-008 In WR, aw_valid and w_valid SHALL be asserted from the cycle after grant. Each SHALL drop independently after its own handshake.
REQ-009 WR SHALL go to WR_RESP once both handshakes have completed, in the same cycle or in different cycles, in either order.
REQ-010 In WR_RESP, b_ready SHALL be 1. On b_valid the FSM SHALL return to IDLE.
REQ-011 In RD_ADDR, ar_valid SHALL be 1 until ar_ready, then the FSM SHALL go to RD_DATA.
REQ-012 In RD_DATA, r_ready SHALL be 1. On r_valid&r_last the block SHALL capture r_data and return to IDLE.
REQ-013 rvalid_o SHALL pulse exactly one cycle, the cycle after the B or R handshake.
- rdata_o SHALL hold its last captured value until the next read completes.
- err_o SHALL equal resp[1] of that response.
REQ-014 Constant AXI fields SHALL be:
- len=0, size=log2(AXI_DATA_WIDTH/8), burst=INCR, last=1.
- lock, cache, prot, qos, region and user = 0.
- id=AXI_ID.
- w_strb = registered we_i.
REQ-015 Valid signals SHALL never depend combinationally on ready signals, and SHALL stay stable until their handshake.
REQ-016 Minimum latency SHALL be: grant at cycle 0, address valid at cycle 1, rvalid_o at cycle 3 when the slave responds in the cycle after the address handshake.
REQ-017 req_i asserted outside IDLE SHALL be ignored, with no gnt_o, until the FSM reaches IDLE.
REQ-018 A new request SHALL be grantable in the IDLE cycle that coincides with rvalid_o.

Reset
REQ-019 Asserting rst SHALL immediately, including mid-transaction, force:
- state IDLE;
- all AXI valid and ready signals 0;
- gnt_o, rvalid_o, err_o 0;
- rdata_o 0;
- last_addr_o 0;
- internal registers 0.
REQ-020 After rst deasserts, the first grant SHALL be possible on the first clock edge.

Configuration
REQ-021 Macro BRAM_AXI_MASTER_TRACE_EN SHALL select trace behaviour.
- Defined: last_addr_o SHALL register addr_i at every grant, for 7-segment debug display.
- Undefined: last_addr_o SHALL be constant 0 and no trace register SHALL be built.

Verification
REQ-022 Write: req_i=1, we_i=8'hFF, addr_i=32'h4000_0010, wdata_i=64'hDEAD_BEEF_0123_4567. Slave ready immediately, OKAY. Required: gnt_o at cycle 0, aw_addr=32'h4000_0010, w_strb=8'hFF, w_last=1, rvalid_o=1 and err_o=0 at cycle 3.
REQ-023 Read: we_i=0, addr_i=32'h4200_0008. Slave returns r_data=64'h1122_3344_5566_7788 with OKAY after 5 wait cycles. Required: one rvalid_o pulse, rdata_o=64'h1122_3344_5566_7788, ar_len=0, ar_size=3.
REQ-024 Skewed write handshakes: w_ready 4 cycles before aw_ready. Required: w_valid drops after its handshake, aw_valid held until aw_ready, b_ready only after both handshakes.
REQ-025 Error and back-to-back: a read returns SLVERR (2'b10) while req_i stays high. Required: err_o=1 with rvalid_o, and the next request granted in the rvalid_o cycle.
REQ-026 Reset mid-read: assert rst while ar_valid=1. Required: ar_valid=0 in the same cycle, last_addr_o=0, no rvalid_o after release.
- With BRAM_AXI_MASTER_TRACE_EN: last_addr_o=32'h4200_0008 after the REQ-023 grant.
- Without it: last_addr_o stays 0.
